// File: rtl/crc_pkg.sv
// crc_pkg: shared CRC state type, ISO14443 CRC_A/CRC_B constants and single-bit update.
package crc_pkg;
  typedef enum logic {IDLE, SHIFT} crc_state_e;
  localparam logic [15:0] CRC_A_POLY = 16'h1021;
  localparam logic [15:0] CRC_A_INIT = 16'h6363;
  localparam logic [15:0] CRC_A_XOR = 16'h0000;
  localparam logic [15:0] CRC_B_POLY = 16'h1021;
  localparam logic [15:0] CRC_B_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_B_XOR = 16'hFFFF;
  // Reflected mode shifts right against the bit-reversed polynomial; r must be zero above width.
  function automatic logic [31:0] crc_step(input logic [31:0] r, input logic b, input int width,
                                           input logic [31:0] poly, input bit lsb_first);
    logic [31:0] rp, mask;
    logic fb;
    mask = 32'((64'd1 << width) - 64'd1);
    rp = {<<{poly}};
    rp = rp >> (32 - width);
    fb = b ^ (lsb_first ? r[0] : r[5'(width - 1)]);
    return lsb_first ? ((r >> 1) ^ (fb ? rp : 32'd0)) : (((r << 1) ^ (fb ? poly : 32'd0)) & mask);
  endfunction
endpackage

// File: rtl/crc_step_unroll.sv
// crc_step_unroll: applies up to B single-bit CRC updates in one cycle, gated per bit by en.
module crc_step_unroll import crc_pkg::*; #(
  parameter int CRC_WIDTH = 16,
  parameter logic [CRC_WIDTH-1:0] POLY = CRC_A_POLY,
  parameter bit LSB_FIRST = 1'b1,
  parameter int B = 1
) (
  input  logic [CRC_WIDTH-1:0] crc_in,
  input  logic [B-1:0]         bits,
  input  logic [B-1:0]         en,
  output logic [CRC_WIDTH-1:0] crc_out
);
  logic [31:0] acc;
  always_comb begin
    acc = 32'(crc_in);
    for (int i = 0; i < B; i++) acc = en[i] ? crc_step(acc, bits[i], CRC_WIDTH, 32'(POLY), LSB_FIRST) : acc;
    crc_out = CRC_WIDTH'(acc);
  end
endmodule

// File: rtl/crc_engine.sv
// crc_engine: parametrised CRC over valid/ready words; CRC_ENGINE_BIT_STREAM_EN adds legacy bit-serial data/sample input.
module crc_engine import crc_pkg::*; #(
  parameter int CRC_WIDTH = 16,
  parameter logic [CRC_WIDTH-1:0] POLY = CRC_A_POLY,
  parameter logic [CRC_WIDTH-1:0] INIT = CRC_A_INIT,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT = CRC_A_XOR,
  parameter int DATA_WIDTH = 8,
  parameter int BITS_PER_CYCLE = 1,
  parameter bit LSB_FIRST = 1'b1,
  localparam int BW = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [BW-1:0]         in_bits,
`ifdef CRC_ENGINE_BIT_STREAM_EN
  input  logic                  data,
  input  logic                  sample,
  output logic                  sample_dropped,
`endif
  output logic                  busy,
  output logic [CRC_WIDTH-1:0]  crc,
  output logic                  crc_zero
);
  crc_state_e state_q, state_d;
  logic [CRC_WIDTH-1:0] crc_q, crc_d, step_out;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [BW-1:0] rem_q, rem_d, n, k;
  logic [BITS_PER_CYCLE-1:0] bits, en;
  logic accept;
  assign accept = state_q == IDLE && in_valid;
  assign n = (in_bits == '0 || in_bits > BW'(DATA_WIDTH)) ? BW'(DATA_WIDTH) : in_bits;
  assign k = rem_q > BW'(BITS_PER_CYCLE) ? BW'(BITS_PER_CYCLE) : rem_q;
  assign in_ready = state_q == IDLE;
  assign busy = state_q == SHIFT;
  assign crc = crc_q ^ XOR_OUT;
  assign crc_zero = crc_q == '0;
  // MSb-first words are left-aligned on capture so the stream always leaves from the top.
  always_comb
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      bits[i] = LSB_FIRST ? data_q[i] : data_q[DATA_WIDTH-1-i];
      en[i] = BW'(i) < rem_q;
    end
  crc_step_unroll #(.CRC_WIDTH(CRC_WIDTH), .POLY(POLY), .LSB_FIRST(LSB_FIRST), .B(BITS_PER_CYCLE)) u_unroll (
    .crc_in(crc_q), .bits(bits), .en(en), .crc_out(step_out)
  );
  always_comb begin
    state_d = state_q;
    crc_d = crc_q;
    data_d = data_q;
    rem_d = rem_q;
    if (start) begin
      crc_d = INIT;
      state_d = IDLE;
      rem_d = '0;
    end
    if (accept) begin
      data_d = LSB_FIRST ? in_data : in_data << (BW'(DATA_WIDTH) - n);
      rem_d = n;
      state_d = SHIFT;
    end else if (state_q == SHIFT && !start) begin
      crc_d = step_out;
      data_d = LSB_FIRST ? data_q >> BITS_PER_CYCLE : data_q << BITS_PER_CYCLE;
      rem_d = rem_q - k;
      state_d = rem_q == k ? IDLE : SHIFT;
    end
`ifdef CRC_ENGINE_BIT_STREAM_EN
    else if (state_q == IDLE && sample && !start)
      crc_d = CRC_WIDTH'(crc_step(32'(crc_q), data, CRC_WIDTH, 32'(POLY), LSB_FIRST));
`endif
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      crc_q <= INIT;
      data_q <= '0;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      crc_q <= crc_d;
      data_q <= data_d;
      rem_q <= rem_d;
    end
`ifdef CRC_ENGINE_BIT_STREAM_EN
  always_ff @(posedge clk)
    if (rst || start) sample_dropped <= 1'b0;
    else if (sample && (busy || accept)) sample_dropped <= 1'b1;
`endif
endmodule

// File: tb/tb_crc_engine.sv
// tb_crc_engine: directed checks of CRC_A (1 and 4 bits/cycle) and CRC_B (8 bits/cycle) engines.
module tb_crc_engine;
  import crc_pkg::*;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [7:0] in_data = '0;
  logic [3:0] in_bits = '0;
  logic ra, r4, rb, ba, b4, bb, za, z4, zb;
  logic [15:0] ca, c4, cb;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  crc_engine dut_a (.clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(ra),
    .in_data(in_data), .in_bits(in_bits), .busy(ba), .crc(ca), .crc_zero(za));
  crc_engine #(.BITS_PER_CYCLE(4)) dut_a4 (.clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(r4), .in_data(in_data), .in_bits(in_bits), .busy(b4), .crc(c4), .crc_zero(z4));
  crc_engine #(.INIT(CRC_B_INIT), .XOR_OUT(CRC_B_XOR), .BITS_PER_CYCLE(8)) dut_b (.clk(clk), .rst(rst),
    .start(start), .in_valid(in_valid), .in_ready(rb), .in_data(in_data), .in_bits(in_bits), .busy(bb),
    .crc(cb), .crc_zero(zb));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(ra && r4 && rb) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("idle_timeout", 32'(t), 32'd0);
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] nb);
    wait_idle();
    in_data = d;
    in_bits = nb;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic pulse_start();
    wait_idle();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  function automatic logic [15:0] mdl(input logic [15:0] c, input logic [7:0] d, input int nb);
    logic [31:0] r = 32'(c);
    for (int i = 0; i < nb; i++) r = crc_step(r, d[i], 16, 32'h1021, 1'b1);
    return r[15:0];
  endfunction

  initial begin
    logic [15:0] ma, mb;
    logic [7:0] d;
    int len, na, n4, nb8;
    repeat (2) @(negedge clk);
    rst = 0;
    check("reset_crc_a", 32'(ca), 32'h6363);
    check("reset_zero_a", 32'(za), 32'd0);
    check("reset_ready_a", 32'(ra), 32'd1);
    check("reset_busy_a", 32'(ba), 32'd0);
    check("reset_crc_b", 32'(cb), 32'h0000);
    check("reset_zero_b", 32'(zb), 32'd0);
    send(8'h00, 4'd0);
    send(8'h00, 4'd0);
    wait_idle();
    check("a_0000_b1", 32'(ca), 32'h1EA0);
    check("a_0000_b4", 32'(c4), 32'h1EA0);
    pulse_start();
    check("start_empty_a", 32'(ca), 32'h6363);
    check("start_empty_zero", 32'(za), 32'd0);
    send(8'h12, 4'd0);
    send(8'h34, 4'd0);
    wait_idle();
    check("a_1234_b1", 32'(ca), 32'hCF26);
    check("a_1234_b4", 32'(c4), 32'hCF26);
    pulse_start();
    for (int i = 0; i < 3; i++) send(8'h00, 4'd0);
    wait_idle();
    check("b_000000", 32'(cb), 32'hC6CC);
    pulse_start();
    send(8'h0F, 4'd0);
    send(8'hAA, 4'd0);
    send(8'hFF, 4'd0);
    wait_idle();
    check("b_0faaff", 32'(cb), 32'hD1FC);
    // 15-bit short frame and busy duration per engine
    pulse_start();
    send(8'h93, 4'd0);
    send(8'h26, 4'd7);
    na = 0; n4 = 0; nb8 = 0;
    for (int t = 0; t < 50 && !(ra && r4 && rb); t++) begin
      na += int'(ba); n4 += int'(b4); nb8 += int'(bb);
      @(negedge clk);
    end
    ma = mdl(mdl(16'h6363, 8'h93, 8), 8'h26, 7);
    mb = mdl(mdl(16'hFFFF, 8'h93, 8), 8'h26, 7);
    check("short_crc_b1", 32'(ca), 32'(ma));
    check("short_crc_b4", 32'(c4), 32'(ma));
    check("short_crc_b8", 32'(cb), 32'(mb ^ 16'hFFFF));
    check("short_busy_b1", 32'(na), 32'd7);
    check("short_busy_b4", 32'(n4), 32'd2);
    check("short_busy_b8", 32'(nb8), 32'd1);
    // abort mid-shift
    send(8'hFF, 4'd0);
    check("abort_busy_before", 32'(ba & b4 & bb), 32'd1);
    start = 1;
    @(negedge clk);
    start = 0;
    check("abort_ready_a", 32'(ra), 32'd1);
    check("abort_ready_b", 32'(rb), 32'd1);
    check("abort_crc_a", 32'(ca), 32'h6363);
    check("abort_crc_a4", 32'(c4), 32'h6363);
    check("abort_crc_b", 32'(cb), 32'h0000);
    // start coincident with an accepted word
    send(8'h55, 4'd0);
    wait_idle();
    start = 1;
    in_data = 8'h00;
    in_bits = 4'd0;
    in_valid = 1;
    @(negedge clk);
    start = 0;
    in_valid = 0;
    wait_idle();
    check("start_accept_a", 32'(ca), 32'(mdl(16'h6363, 8'h00, 8)));
    check("start_accept_a4", 32'(c4), 32'(mdl(16'h6363, 8'h00, 8)));
    check("start_accept_b", 32'(cb), 32'(mdl(16'hFFFF, 8'h00, 8) ^ 16'hFFFF));
    // random frames plus CRC_A residue
    for (int f = 0; f < 30; f++) begin
      pulse_start();
      ma = 16'h6363;
      mb = 16'hFFFF;
      len = $urandom_range(1, 20);
      for (int j = 0; j < len; j++) begin
        d = 8'($urandom);
        send(d, 4'd0);
        ma = mdl(ma, d, 8);
        mb = mdl(mb, d, 8);
      end
      wait_idle();
      check("rand_a", 32'(ca), 32'(ma));
      check("rand_a4", 32'(c4), 32'(ma));
      check("rand_b", 32'(cb), 32'(mb ^ 16'hFFFF));
      send(ma[7:0], 4'd0);
      send(ma[15:8], 4'd0);
      wait_idle();
      check("residue_a", 32'(za), 32'd1);
      check("residue_a4", 32'(z4), 32'd1);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rereset_crc_a", 32'(ca), 32'h6363);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
